// File: rtl/execucao.sv
// rtl/execucao.sv - MIPS execute stage: registered ALU result, store data and memory control
//
// Purpose:
//    Accepts one instruction when in_valid && !stall and computes its ALU result.
//    The result, the store data and the memory control bits are registered and
//    handed to the memory stage. Single-cycle operations complete one cycle after
//    accept. With EXECUCAO_MULDIV_EN defined, MULTU/DIVU run iteratively for 32
//    cycles (stall held high) and write their upper/remainder word to HI. MFHI
//    reads HI.
//
// Configuration macro: EXECUCAO_MULDIV_EN (undefined: no HI, no BUSY, stall = 0)
//
// Ports:
//    clk, rst                         clock, synchronous active-high reset
//    in_valid                         upstream instruction present
//    aluop[3:0]                       operation select
//    valor1[31:0], valor2_in[31:0]    operands A (rs) and B / store data (rt)
//    shamt[4:0]                       shift amount for SLL/SRL
//    memwrite_in/memread_in/memtoreg_in  control bits passed through
//    aluresult[31:0], valor2[31:0]    registered result / address and store data
//    memwrite/memread/memtoreg        registered control (memwrite only with out_valid)
//    zero                             registered aluresult == 0
//    out_valid                        one-cycle pulse per completed instruction
//    stall                            multi-cycle op in progress, upstream holds

module execucao (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [3:0]  aluop,
   input  logic [31:0] valor1,
   input  logic [31:0] valor2_in,
   input  logic [4:0]  shamt,
   input  logic        memwrite_in,
   input  logic        memread_in,
   input  logic        memtoreg_in,
   output logic [31:0] aluresult,
   output logic [31:0] valor2,
   output logic        memwrite,
   output logic        memread,
   output logic        memtoreg,
   output logic        zero,
   output logic        out_valid,
   output logic        stall
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
`ifdef EXECUCAO_MULDIV_EN
   localparam logic [3:0] OP_MULTU = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_MFHI  = 4'b1101;
`endif

   logic        accept;
   logic [31:0] alu_result;

   assign accept = in_valid && !stall;

`ifdef EXECUCAO_MULDIV_EN
   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] hi;
   logic        is_div;
   // Shared iteration registers: acc_hi is the partial product upper word or the
   // running remainder; acc_lo is the multiplier/product low word or the
   // dividend/quotient; opnd is the multiplicand or the divisor.
   logic [31:0] acc_hi, acc_lo, opnd;
   logic [31:0] pend_valor2;
   logic        pend_memwrite, pend_memread, pend_memtoreg;
   logic        start_md;
   logic        last_iter;

   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic [32:0] div_diff;
   logic [31:0] step_hi, step_lo;

   assign start_md  = accept && (aluop == OP_MULTU || aluop == OP_DIVU);
   assign last_iter = (state == BUSY) && (cnt == 5'd31);
   assign stall     = (state == BUSY);

   // One shift-add or restoring-divide step. With a zero divisor the
   // subtraction never goes negative, so the quotient fills with ones and the
   // remainder ends up equal to the dividend without any special case.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
      rem_sh   = {acc_hi, acc_lo[31]};
      div_diff = rem_sh - {1'b0, opnd};
      step_hi  = 32'd0;
      step_lo  = 32'd0;
      if (is_div) begin
         if (!div_diff[32]) begin
            step_hi = div_diff[31:0];
            step_lo = {acc_lo[30:0], 1'b1};
         end else begin
            step_hi = rem_sh[31:0];
            step_lo = {acc_lo[30:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[32:1];
         step_lo = {mul_sum[0], acc_lo[31:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_md) state_nxt = BUSY;
         BUSY: if (cnt == 5'd31) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      alu_result = 32'd0;
      case (aluop)
         OP_AND:   alu_result = valor1 & valor2_in;
         OP_OR:    alu_result = valor1 | valor2_in;
         OP_ADD:   alu_result = valor1 + valor2_in;
         OP_SUB:   alu_result = valor1 - valor2_in;
         OP_SLT:   alu_result = ($signed(valor1) < $signed(valor2_in)) ? 32'd1 : 32'd0;
         OP_NOR:   alu_result = ~(valor1 | valor2_in);
         OP_SLL:   alu_result = valor2_in << shamt;
         OP_SRL:   alu_result = valor2_in >> shamt;
`ifdef EXECUCAO_MULDIV_EN
         OP_MFHI:  alu_result = hi;
`endif
         default:  alu_result = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aluresult <= 32'd0;
         valor2    <= 32'd0;
         memwrite  <= 1'b0;
         memread   <= 1'b0;
         memtoreg  <= 1'b0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
`ifdef EXECUCAO_MULDIV_EN
         cnt           <= 5'd0;
         hi            <= 32'd0;
         is_div        <= 1'b0;
         acc_hi        <= 32'd0;
         acc_lo        <= 32'd0;
         opnd          <= 32'd0;
         pend_valor2   <= 32'd0;
         pend_memwrite <= 1'b0;
         pend_memread  <= 1'b0;
         pend_memtoreg <= 1'b0;
`endif
      end else begin
         // memwrite only ever lives for the out_valid cycle
         out_valid <= 1'b0;
         memwrite  <= 1'b0;
`ifdef EXECUCAO_MULDIV_EN
         if (start_md) begin
            cnt           <= 5'd0;
            is_div        <= (aluop == OP_DIVU);
            acc_hi        <= 32'd0;
            acc_lo        <= valor1;
            opnd          <= valor2_in;
            pend_valor2   <= valor2_in;
            pend_memwrite <= memwrite_in;
            pend_memread  <= memread_in;
            pend_memtoreg <= memtoreg_in;
         end else if (accept) begin
`else
         if (accept) begin
`endif
            aluresult <= alu_result;
            zero      <= (alu_result == 32'd0);
            valor2    <= valor2_in;
            memwrite  <= memwrite_in;
            memread   <= memread_in;
            memtoreg  <= memtoreg_in;
            out_valid <= 1'b1;
         end
`ifdef EXECUCAO_MULDIV_EN
         else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
            if (last_iter) begin
               aluresult <= step_lo;
               zero      <= (step_lo == 32'd0);
               hi        <= step_hi;
               valor2    <= pend_valor2;
               memwrite  <= pend_memwrite;
               memread   <= pend_memread;
               memtoreg  <= pend_memtoreg;
               out_valid <= 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_execucao.sv
// tb/tb_execucao.sv - scoreboard bench for the execucao execute stage

module tb_execucao;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  aluop = 4'd0;
   logic [31:0] valor1 = 32'd0;
   logic [31:0] valor2_in = 32'd0;
   logic [4:0]  shamt = 5'd0;
   logic        memwrite_in = 1'b0;
   logic        memread_in = 1'b0;
   logic        memtoreg_in = 1'b0;
   logic [31:0] aluresult, valor2;
   logic        memwrite, memread, memtoreg, zero, out_valid, stall;

   execucao dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .aluop(aluop),
      .valor1(valor1), .valor2_in(valor2_in), .shamt(shamt),
      .memwrite_in(memwrite_in), .memread_in(memread_in), .memtoreg_in(memtoreg_in),
      .aluresult(aluresult), .valor2(valor2), .memwrite(memwrite),
      .memread(memread), .memtoreg(memtoreg), .zero(zero),
      .out_valid(out_valid), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] v2;
      logic        mw, mr, mt;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          stall_run = 0;
   logic [31:0] hi_model = 32'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] r);
      logic [63:0] p;
      r = 32'd0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: r = ~(a | b);
         4'b1000: r = b << sh;
         4'b1001: r = b >> sh;
`ifdef EXECUCAO_MULDIV_EN
         4'b1010: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; hi_model = p[63:32]; end
         4'b1011: begin
            if (b == 32'd0) begin r = 32'hFFFF_FFFF; hi_model = a; end
            else begin r = a / b; hi_model = a % b; end
         end
         4'b1101: r = hi_model;
`endif
         default: r = 32'd0;
      endcase
   endtask

   // Holds the instruction on the inputs until the DUT takes it.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic mw, input logic mr, input logic mt);
      exp_t e;
      int   guard;
      aluop = op; valor1 = a; valor2_in = b; shamt = sh;
      memwrite_in = mw; memread_in = mr; memtoreg_in = mt;
      in_valid = 1'b1;
      guard = 0;
      while (stall && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) check("accept_timeout", 1, 0);
      model(op, a, b, sh, e.res);
      e.v2 = b; e.mw = mw; e.mr = mr; e.mt = mt;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain;
      int guard = 0;
      while ((sb.size() != 0 || stall) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) check("drain_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall_run = 0;
      end else begin
         if (stall) begin
            stall_run++;
         end else if (stall_run != 0) begin
            check("stall_len", stall_run, 32);
            stall_run = 0;
         end
`ifndef EXECUCAO_MULDIV_EN
         if (stall) check("stall_tied_low", stall, 0);
`endif
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("aluresult", aluresult, e.res);
               check("zero", zero, (e.res == 32'd0));
               check("valor2", valor2, e.v2);
               check("memwrite", memwrite, e.mw);
               check("memread", memread, e.mr);
               check("memtoreg", memtoreg, e.mt);
            end
         end else if (memwrite) begin
            check("memwrite_without_valid", memwrite, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_aluresult", aluresult, 0);
      check("rst_valor2", valor2, 0);
      check("rst_zero", zero, 1);
      check("rst_ctrl", {memwrite, memread, memtoreg}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_stall", stall, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(4'b0010, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b0110, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0, 1'b1);
      issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 1'b0, 1'b1, 1'b1);
      issue(4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1100, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1000, 32'd0, 32'h8000_0001, 5'd31, 1'b0, 1'b0, 1'b0);
      issue(4'b1001, 32'd0, 32'h8000_0001, 5'd4, 1'b0, 1'b0, 1'b0);
      issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1111, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();

      issue(4'b1010, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0, 1'b0, 1'b1);
      issue(4'b1101, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1011, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1101, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1011, 32'd5, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1101, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0, 1'b1, 1'b0);
      // store held on the inputs while the multiply stalls
      issue(4'b0010, 32'd8, 32'hAB, 5'd0, 1'b1, 1'b0, 1'b0);
      issue(4'b1101, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();

`ifdef EXECUCAO_MULDIV_EN
      aluop = 4'b1011; valor1 = 32'd1000; valor2_in = 32'd3; shamt = 5'd0;
      memwrite_in = 1'b0; memread_in = 1'b0; memtoreg_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("div_started", stall, 1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      hi_model = 32'd0;
      check("rst_abort_stall", stall, 0);
      check("rst_abort_out_valid", out_valid, 0);
      repeat (40) @(posedge clk);
      #1;
      issue(4'b1101, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b0010, 32'd20, 32'd22, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();
`endif

      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
